// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: control, status and SPI pin bundle for spi_master_ctrl.
interface spi_master_ctrl_if #(parameter int DATA_WIDTH = 8);
    logic                  start, abort, cpol, cpha, miso;
    logic                  sclk, mosi, cs_n, busy, done;
    logic [DATA_WIDTH-1:0] tx_data, rx_data;
    modport master (
        input  start, abort, cpol, cpha, tx_data, miso,
        output sclk, mosi, cs_n, busy, done, rx_data
    );
    modport slave (
        output start, abort, cpol, cpha, tx_data, miso,
        input  sclk, mosi, cs_n, busy, done, rx_data
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master for all four cpol/cpha modes with registered pins.
// Pin registers follow the current state, so they trail state changes by one cycle.
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input logic clk,
    input logic rst,
    spi_master_ctrl_if.master bus
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, DONE} state_t;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  lead_q, lead_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, sh_q, sh_d, rx_q, rx_d;
    logic                  sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, done_q, done_d;
    logic                  tick, last, kill;
    assign tick = cnt_q == CW'(CLK_DIV - 1);
    assign kill = bus.abort && (state_q inside {SETUP, TRANSFER, HOLD});
    // final toggle is the trailing edge after the last sample (cpha=0) or carrying it (cpha=1)
    assign last = !lead_q && (bit_q == (cpha_q ? BW'(DATA_WIDTH - 1) : BW'(DATA_WIDTH)));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            lead_q  <= 1'b1;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            tx_q    <= '0;
            sh_q    <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            lead_q  <= lead_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            tx_q    <= tx_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     state_d = bus.start ? SETUP : IDLE;
            SETUP:    state_d = tick ? TRANSFER : SETUP;
            TRANSFER: state_d = (tick && last) ? HOLD : TRANSFER;
            HOLD:     state_d = tick ? DONE : HOLD;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end
    always_comb begin
        cnt_d  = (state_d != state_q || tick || state_q == IDLE) ? '0 : cnt_q + 1'b1;
        bit_d  = bit_q;
        lead_d = lead_q;
        cpol_d = cpol_q;
        cpha_d = cpha_q;
        tx_d   = tx_q;
        sh_d   = sh_q;
        rx_d   = rx_q;
        sclk_d = cpol_q;
        mosi_d = mosi_q;
        cs_n_d = 1'b0;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                sclk_d = bus.cpol;
                mosi_d = 1'b0;
                cs_n_d = 1'b1;
                if (bus.start) begin
                    cpol_d = bus.cpol;
                    cpha_d = bus.cpha;
                    tx_d   = bus.tx_data;
                    sh_d   = '0;
                    bit_d  = '0;
                    lead_d = 1'b1;
                end
            end
            SETUP: mosi_d = cpha_q ? 1'b0 : tx_q[DATA_WIDTH-1];
            TRANSFER: begin
                sclk_d = tick ? ~sclk_q : sclk_q;
                if (tick) begin
                    lead_d = ~lead_q;
                    if (lead_q == cpha_q && !last) begin
                        mosi_d = cpha_q ? tx_q[DATA_WIDTH-1] : tx_q[DATA_WIDTH-2];
                        tx_d   = tx_q << 1;
                    end
                    if (lead_q != cpha_q) begin
                        sh_d  = {sh_q[DATA_WIDTH-2:0], bus.miso};
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            HOLD: ;
            DONE: begin
                mosi_d = 1'b0;
                cs_n_d = 1'b1;
                done_d = 1'b1;
                rx_d   = sh_q;
            end
            default: cs_n_d = 1'b1;
        endcase
        if (kill) begin
            sclk_d = cpol_q;
            mosi_d = 1'b0;
            cs_n_d = 1'b1;
        end
    end
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.busy    = state_q != IDLE;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_q;
endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per transfer (>=2).
REQ-002 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period (>=1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  transfer request, sampled in IDLE only.
REQ-006 abort  input  1  synchronous cancel of an active transfer.
REQ-007 cpol  input  1  SCLK idle level, latched at start acceptance.
REQ-008 cpha  input  1  clock phase, latched at start acceptance.
REQ-009 tx_data  input  DATA_WIDTH  word to send, latched at start acceptance.
REQ-010 miso  input  1  serial data from slave.
REQ-011 sclk  output  1  registered serial clock.
REQ-012 mosi  output  1  registered serial data to slave, MSB first.
REQ-013 cs_n  output  1  registered active-low chip select.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 rx_data  output  DATA_WIDTH  last completed received word.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, TRANSFER, HOLD, DONE.
REQ-018 IDLE: start=1 -> latch tx_data/cpol/cpha, enter SETUP; else stay; sclk <= cpol input each cycle, mosi=0, cs_n=1.
REQ-019 SETUP: cs_n=0, sclk=latched cpol, lasts exactly CLK_DIV cycles, then TRANSFER.
REQ-020 Half-period counter: counts 0..CLK_DIV-1, reloads to 0 on every state change; tick = count==CLK_DIV-1.
REQ-021 TRANSFER: sclk toggles on each tick; exactly 2*DATA_WIDTH toggles, then HOLD with sclk back at cpol.
REQ-022 Odd toggles are leading edges, even toggles trailing edges.
REQ-023 cpha=0: mosi = tx MSB from SETUP entry; sample miso on leading edges; shift next bit onto mosi on trailing edges except the last.
REQ-024 cpha=1: shift next bit onto mosi on leading edges (MSB on first); sample miso on trailing edges.
REQ-025 Sampled bits SHALL shift into an internal register MSB first; bit counter counts DATA_WIDTH samples.
REQ-026 HOLD: cs_n=0, sclk=cpol, lasts CLK_DIV cycles, then DONE.
REQ-027 DONE: one cycle; done=1, cs_n=1, rx_data <= shift register; then IDLE.
REQ-028 done SHALL assert exactly (2*DATA_WIDTH+2)*CLK_DIV+1 cycles after the start-accepting edge; cs_n low for (2*DATA_WIDTH+2)*CLK_DIV cycles.
REQ-029 start outside IDLE SHALL be ignored; start held high SHALL launch a new transfer on the first IDLE cycle.
REQ-030 abort=1 in SETUP/TRANSFER/HOLD -> IDLE next edge, cs_n=1, sclk=cpol, mosi=0, no done, rx_data unchanged.
REQ-031 abort in IDLE or DONE SHALL have no effect; abort and start together in IDLE -> start wins.
REQ-032 Changes on tx_data/cpol/cpha while busy SHALL not affect the active transfer.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, sclk=0, mosi=0, cs_n=1, busy=0, done=0, rx_data=0, counters=0.
REQ-034 Reset asserted mid-transfer SHALL abandon it without done pulse; first start after release begins a clean transfer.

Verification
REQ-035 DW=8, CLK_DIV=2, cpol=0 cpha=0, tx=0xA5, miso looped from mosi -> rx_data=0xA5, done 37 cycles after start edge, 16 sclk toggles.
REQ-036 cpol=1 cpha=1, tx=0x3C, slave model drives 0xC3 -> mosi bits 0,0,1,1,1,1,0,0 on leading edges, rx_data=0xC3, sclk idles high.
REQ-037 abort at 5th sclk toggle -> cs_n=1 next cycle, no done, rx_data holds prior 0xA5.
REQ-038 rst pulse mid-TRANSFER -> outputs at reset values asynchronously; next transfer of 0x5A completes correctly.
REQ-039 start held high continuously, CLK_DIV=1 -> back-to-back transfers, one done per transfer, start pulses while busy ignored, cs_n high exactly one cycle (DONE) plus one IDLE cycle between transfers.
